// File: rtl/keypad_pkg.sv
// Shared types, sizes and row helpers for the 4x4 keypad scanner.
// KEYPAD_AUTOREPEAT_EN (see keypad_scanner) needs nothing from this package.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   localparam int KEY_ROWS   = 4;
   localparam int KEY_COLS   = 4;
   localparam int KEY_CODE_W = 4;

   localparam logic [KEY_ROWS-1:0] ROWS_IDLE = 4'hF;

   // Active-low one-hot pattern: used both for column drive and row matching.
   function automatic logic [KEY_ROWS-1:0] low_mask(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   function automatic logic single_low(input logic [KEY_ROWS-1:0] rows);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < KEY_ROWS; i++) begin
         if (!rows[i]) n = n + 3'd1;
         else          n = n;
      end
      return (n == 3'd1);
   endfunction

   function automatic logic [1:0] low_index(input logic [KEY_ROWS-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < KEY_ROWS; i++) begin
         if (!rows[i]) idx = 2'(i);
         else          idx = idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-rate divider: one-cycle tick every CLK_DIV clocks, free-running.
module keypad_tick_gen #(
   parameter int CLK_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_r;

   // divider counter, wraps at CLK_DIV-1
   always_ff @(posedge clk) begin
      if (reset)                 cnt_r <= '0;
      else if (cnt_r == CNT_MAX) cnt_r <= '0;
      else                       cnt_r <= cnt_r + CW'(1);
   end

   assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce, key code and active-low interrupt.
// Define KEYPAD_AUTOREPEAT_EN to pulse key_intr_n while a key stays held.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int CLK_DIV    = 1000,
   parameter int DEB_TICKS  = 16,
   parameter int REPEAT_DLY = 200,
   parameter int REPEAT_PER = 40
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [KEY_ROWS-1:0]   row_n,
   output logic [KEY_COLS-1:0]   col_n,
   output logic [KEY_CODE_W-1:0] key_code,
   output logic                  key_valid,
   output logic                  key_intr_n
);

   localparam int DEB_W = $clog2(DEB_TICKS + 1);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_TICKS);

   logic [KEY_ROWS-1:0] sync1_r, rows_s;
   logic                tick_s;
   kp_state_t           state_r, state_nx;
   logic [1:0]          col_r, col_nx, row_idx_r, row_idx_nx, col_idx_r, col_idx_nx;
   logic [DEB_W-1:0]    deb_r, deb_nx;
   logic [KEY_COLS-1:0] col_n_r;
   logic [3:0]          code_r, code_nx;
   logic                valid_r, valid_nx, intr_n_r, intr_n_nx;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   logic [REP_W-1:0] rep_r, rep_nx;
   logic             rep_first_r, rep_first_nx;
`endif

   keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_s)
   );

   // two-flop synchronizer for the asynchronous rows
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= ROWS_IDLE;
         rows_s  <= ROWS_IDLE;
      end else begin
         sync1_r <= row_n;
         rows_s  <= sync1_r;
      end
   end

   // FSM next state; everything holds between ticks
   always_comb begin
      state_nx   = state_r;
      col_nx     = col_r;
      row_idx_nx = row_idx_r;
      col_idx_nx = col_idx_r;
      deb_nx     = deb_r;
      code_nx    = code_r;
      valid_nx   = valid_r;
      intr_n_nx  = intr_n_r;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_nx       = rep_r;
      rep_first_nx = rep_first_r;
`endif
      if (tick_s) begin
         case (state_r)
            SCAN: begin
               if (single_low(rows_s)) begin
                  row_idx_nx = low_index(rows_s);
                  col_idx_nx = col_r;
                  deb_nx     = DEB_W'(1);
                  state_nx   = DEBOUNCE;
               end else begin
                  col_nx = col_r + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (rows_s == low_mask(row_idx_r)) begin
                  if (deb_r == DEB_MAX) begin
                     code_nx   = {row_idx_r, col_idx_r};
                     valid_nx  = 1'b1;
                     intr_n_nx = 1'b0;
                     state_nx  = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_nx       = '0;
                     rep_first_nx = 1'b0;
`endif
                  end else begin
                     deb_nx = deb_r + DEB_W'(1);
                  end
               end else begin
                  state_nx = SCAN;
                  col_nx   = col_r + 2'd1;
               end
            end
            HELD: begin
               if (rows_s == ROWS_IDLE) begin
                  deb_nx    = DEB_W'(1);
                  intr_n_nx = 1'b0;
                  state_nx  = RELEASE;
               end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                  // high for exactly one tick at each repeat point
                  rep_nx = rep_r + REP_W'(1);
                  if ((!rep_first_r && (rep_nx == REP_W'(REPEAT_DLY))) ||
                      ( rep_first_r && (rep_nx == REP_W'(REPEAT_PER)))) begin
                     intr_n_nx    = 1'b1;
                     rep_nx       = '0;
                     rep_first_nx = 1'b1;
                  end else begin
                     intr_n_nx = 1'b0;
                  end
`else
                  intr_n_nx = 1'b0;
`endif
               end
            end
            RELEASE: begin
               if (rows_s == ROWS_IDLE) begin
                  if (deb_r == DEB_MAX) begin
                     valid_nx  = 1'b0;
                     intr_n_nx = 1'b1;
                     state_nx  = SCAN;
                     col_nx    = col_r + 2'd1;
                  end else begin
                     deb_nx = deb_r + DEB_W'(1);
                  end
               end else if (!rows_s[row_idx_r]) begin
                  state_nx = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_nx       = '0;
                  rep_first_nx = 1'b0;
`endif
               end else begin
                  state_nx = RELEASE;
               end
            end
            default: begin
               state_nx = SCAN;
            end
         endcase
      end else begin
         state_nx = state_r;
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= SCAN;
         col_r     <= 2'd0;
         col_n_r   <= 4'b1110;
         row_idx_r <= 2'd0;
         col_idx_r <= 2'd0;
         deb_r     <= '0;
         code_r    <= 4'd0;
         valid_r   <= 1'b0;
         intr_n_r  <= 1'b1;
      end else begin
         state_r   <= state_nx;
         col_r     <= col_nx;
         col_n_r   <= low_mask(col_nx);
         row_idx_r <= row_idx_nx;
         col_idx_r <= col_idx_nx;
         deb_r     <= deb_nx;
         code_r    <= code_nx;
         valid_r   <= valid_nx;
         intr_n_r  <= intr_n_nx;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // repeat timing registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_r       <= '0;
         rep_first_r <= 1'b0;
      end else begin
         rep_r       <= rep_nx;
         rep_first_r <= rep_first_nx;
      end
   end
`endif

   assign col_n      = col_n_r;
   assign key_code   = code_r;
   assign key_valid  = valid_r;
   assign key_intr_n = intr_n_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (CLK_DIV=4, DEB_TICKS=3, REPEAT_DLY=5, REPEAT_PER=2).
// Edge numbers count clock edges since reset release; scan ticks land on multiples of 4.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_intr_n;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int falls  = 0;
   int f_base;

   keypad_scanner #(
      .CLK_DIV    (4),
      .DEB_TICKS  (3),
      .REPEAT_DLY (5),
      .REPEAT_PER (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .row_n      (row_n),
      .col_n      (col_n),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_intr_n (key_intr_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge key_intr_n) falls++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic goto_edge(input int k);
      while (edge_n < k) step();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset  = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [3:0] rot [5];
      int         rep_e [11];
      logic       rep_v [11];
      rot   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      rep_e = '{143, 144, 147, 148, 151, 152, 156, 160, 164, 168, 172};
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
      rep_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

      row_n = 4'hF;
      reset = 1'b1;
      do_reset(3);
      check("rst_col", col_n, 4'b1110);
      check("rst_code", key_code, 4'd0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_intr", key_intr_n, 1'b1);

      // idle rotation, one column per tick
      for (int k = 1; k <= 4; k++) begin
         goto_edge(4 * k - 1);
         check("rot_hold", col_n, rot[k-1]);
         goto_edge(4 * k);
         check("rot_step", col_n, rot[k]);
      end

      // clean press row 2, col 1
      do_reset(3);
      goto_edge(4);
      check("press_col1", col_n, 4'b1101);
      f_base = falls;
      row_n = 4'b1011;
      goto_edge(8);
      check("capture_frozen", col_n, 4'b1101);
      goto_edge(12);
      check("deb_frozen", col_n, 4'b1101);
      goto_edge(19);
      check("pre_accept_intr", key_intr_n, 1'b1);
      check("pre_accept_valid", key_valid, 1'b0);
      goto_edge(20);
      check("accept_intr", key_intr_n, 1'b0);
      check("accept_valid", key_valid, 1'b1);
      check("accept_code", key_code, 4'd9);
      check("accept_falls", falls - f_base, 1);

      // release
      row_n = 4'hF;
      goto_edge(35);
      check("pre_release_valid", key_valid, 1'b1);
      goto_edge(36);
      check("release_valid", key_valid, 1'b0);
      check("release_intr", key_intr_n, 1'b1);
      check("release_code_kept", key_code, 4'd9);
      check("release_col", col_n, 4'b1011);

      // bounce: one tick low, high, then low again in column 3
      f_base = falls;
      row_n = 4'b1110;
      goto_edge(40);
      row_n = 4'hF;
      goto_edge(44);
      check("bounce_abort_col", col_n, 4'b0111);
      row_n = 4'b1110;
      goto_edge(48);
      check("bounce_recapture_col", col_n, 4'b0111);
      goto_edge(59);
      check("bounce_no_intr", key_intr_n, 1'b1);
      check("bounce_no_falls", falls - f_base, 0);
      goto_edge(60);
      check("bounce_accept_intr", key_intr_n, 1'b0);
      check("bounce_accept_code", key_code, 4'd3);

      // release bounce: back to HELD, no second interrupt
      row_n = 4'hF;
      goto_edge(64);
      check("relb_enter_intr", key_intr_n, 1'b0);
      row_n = 4'b1110;
      goto_edge(68);
      check("relb_back_intr", key_intr_n, 1'b0);
      goto_edge(76);
      check("relb_valid", key_valid, 1'b1);
      check("relb_intr", key_intr_n, 1'b0);
      check("relb_one_fall", falls - f_base, 1);
      row_n = 4'hF;
      goto_edge(91);
      check("relb_pre_release", key_valid, 1'b1);
      goto_edge(92);
      check("relb_release_valid", key_valid, 1'b0);
      check("relb_release_intr", key_intr_n, 1'b1);
      check("relb_release_col", col_n, 4'b1110);

      // two rows low in one column: ignored
      row_n = 4'b1001;
      goto_edge(96);
      check("ghost_col_a", col_n, 4'b1101);
      check("ghost_intr", key_intr_n, 1'b1);
      check("ghost_valid", key_valid, 1'b0);
      goto_edge(100);
      check("ghost_col_b", col_n, 4'b1011);
      row_n = 4'hF;

      // hold key 0 for 12 ticks after acceptance
      goto_edge(108);
      check("hold_col0", col_n, 4'b1110);
      row_n = 4'b1110;
      goto_edge(123);
      check("hold_pre_intr", key_intr_n, 1'b1);
      f_base = falls;
      goto_edge(124);
      check("hold_accept_intr", key_intr_n, 1'b0);
      check("hold_accept_code", key_code, 4'd0);
      for (int i = 0; i < 11; i++) begin
         goto_edge(rep_e[i]);
         check("hold_repeat_intr", key_intr_n, rep_v[i]);
         check("hold_repeat_code", key_code, 4'd0);
         check("hold_repeat_valid", key_valid, 1'b1);
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      check("hold_falls", falls - f_base, 5);
`else
      check("hold_falls", falls - f_base, 1);
`endif

      // reset while the key is held
      goto_edge(174);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_col", col_n, 4'b1110);
      check("midrst_code", key_code, 4'd0);
      check("midrst_valid", key_valid, 1'b0);
      check("midrst_intr", key_intr_n, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      edge_n = 0;
      goto_edge(4);
      check("redetect_frozen", col_n, 4'b1110);
      goto_edge(15);
      check("redetect_pre_intr", key_intr_n, 1'b1);
      goto_edge(16);
      check("redetect_intr", key_intr_n, 1'b0);
      check("redetect_valid", key_valid, 1'b1);
      check("redetect_code", key_code, 4'd0);
      row_n = 4'hF;
      goto_edge(32);
      check("final_valid", key_valid, 1'b0);
      check("final_intr", key_intr_n, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
